// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer with a programmable prescaler, answering iomem
// requests inside a 256-byte window with a one-cycle ready pulse and a level interrupt.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam logic [5:0] WordCtrl     = 6'd0;
    localparam logic [5:0] WordPrescale = 6'd1;
    localparam logic [5:0] WordReload   = 6'd2;
    localparam logic [5:0] WordCount    = 6'd3;
    localparam logic [5:0] WordStatus   = 6'd4;

    logic                      sel, access, wr;
    logic [5:0]                word;
    logic [31:0]               wmask;
    logic                      wr_ctrl, wr_prescale, wr_reload, wr_count, clr_status;

    logic [2:0]                ctrl_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q, pre_cnt_q;
    logic [31:0]               reload_q, count_q;
    logic                      expired_q;

    logic                      tick, expire;
    logic [31:0]               rd_val, ctrl_m, prescale_m, reload_m, count_m;
    logic                      unused_bits;

    assign sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign access = sel && !iomem_ready;
    assign wr     = access && (iomem_wstrb != 4'b0000);
    assign word   = iomem_addr[7:2];

    assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

    assign wr_ctrl     = wr && (word == WordCtrl);
    assign wr_prescale = wr && (word == WordPrescale);
    assign wr_reload   = wr && (word == WordReload);
    assign wr_count    = wr && (word == WordCount);
    assign clr_status  = wr && (word == WordStatus) && iomem_wstrb[0] && iomem_wdata[0];

    // Byte-lane merge of the write data into each register's current value
    assign ctrl_m     = ({29'b0, ctrl_q} & ~wmask) | (iomem_wdata & wmask);
    assign prescale_m = (32'(prescale_q) & ~wmask) | (iomem_wdata & wmask);
    assign reload_m   = (reload_q & ~wmask) | (iomem_wdata & wmask);
    assign count_m    = (count_q & ~wmask) | (iomem_wdata & wmask);

    assign tick   = ctrl_q[0] && (pre_cnt_q == prescale_q);
    assign expire = tick && (count_q == 32'd1);

    assign irq = expired_q && ctrl_q[2];

    assign unused_bits = ^{iomem_addr[1:0], ctrl_m[31:3], prescale_m};

    always_comb begin
        rd_val = '0;
        case (word)
            WordCtrl:     rd_val = {29'b0, ctrl_q};
            WordPrescale: rd_val = 32'(prescale_q);
            WordReload:   rd_val = reload_q;
            WordCount:    rd_val = count_q;
            WordStatus:   rd_val = {31'b0, expired_q};
            default:      rd_val = '0;
        endcase
    end

    // Read data reflects register state before any write committed on the same edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= access;
            iomem_rdata <= access ? rd_val : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
            pre_cnt_q  <= '0;
        end else begin
            if (wr_ctrl)     ctrl_q     <= ctrl_m[2:0];
            if (wr_prescale) prescale_q <= prescale_m[PRESCALE_WIDTH-1:0];
            if (wr_reload)   reload_q   <= reload_m;

            if (!ctrl_q[0] || tick || wr_ctrl || wr_prescale) begin
                pre_cnt_q <= '0;
            end else begin
                pre_cnt_q <= pre_cnt_q + PRESCALE_WIDTH'(1);
            end

            // A bus write to COUNT overrides whatever the tick would have done
            if (wr_count) begin
                count_q <= count_m;
            end else if (tick) begin
                if (count_q == 32'd1) begin
                    count_q <= ctrl_q[1] ? reload_q : '0;
                end else if (count_q != 32'd0) begin
                    count_q <= count_q - 32'd1;
                end
            end

            if (expire) begin
                expired_q <= 1'b1;
            end else if (clr_status) begin
                expired_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iomem_timer.sv
// Randomized bench for iomem_timer: bus handshake, byte strobes, one-shot and auto-reload
// timing, same-cycle collisions and asynchronous reset, against an arithmetic timer model.
module tb_iomem_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Timer session model: ticks land on edges s_c0 + k*(s_p+1), k >= 1
    int s_c0, s_p, s_n, s_r;
    bit s_auto;

    iomem_timer #(
        .BASE_ADDR(BASE),
        .PRESCALE_WIDTH(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .iomem_valid(valid),
        .iomem_ready(ready),
        .iomem_wstrb(wstrb),
        .iomem_addr(addr),
        .iomem_wdata(wdata),
        .iomem_rdata(rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ticks_before(input int e);
        if (e - 1 < s_c0) return 0;
        return (e - 1 - s_c0) / (s_p + 1);
    endfunction

    function automatic int count_at(input int e);
        int t;
        t = ticks_before(e);
        if (t < s_n) return s_n - t;
        if (!s_auto) return 0;
        return s_r - ((t - s_n) % s_r);
    endfunction

    function automatic int next_expiry(input int e);
        int k, ed;
        k = s_n;
        for (int i = 0; i < 100000; i++) begin
            ed = s_c0 + k * (s_p + 1);
            if (ed >= e) return ed;
            if (!s_auto) return -1;
            k += s_r;
        end
        return -1;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Drives one request at a negedge and returns #1 after the ready edge (ec = its cycle)
    task automatic bus(input logic [7:0] off, input logic [3:0] ws, input logic [31:0] wd,
                       output logic [31:0] rd, output int ec);
        int lat;
        @(negedge clk);
        for (int i = 0; i < 4 && ready === 1'b1; i++) @(negedge clk);
        valid = 1'b1; addr = BASE | {24'h0, off}; wstrb = ws; wdata = wd;
        lat = -1; rd = '0; ec = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin lat = i; rd = rdata; ec = cyc; break; end
        end
        valid = 1'b0; wstrb = 4'h0;
        n_cmp++;
        if (lat != 1) begin
            n_bad++; $display("FAIL bus_latency off=%h: got %0d cycles, want 1", off, lat);
        end
    endtask

    task automatic wr32(input logic [7:0] off, input logic [31:0] d, output int ec);
        logic [31:0] r;
        bus(off, 4'hF, d, r, ec);
    endtask

    task automatic rd32(input logic [7:0] off, output logic [31:0] d, output int ec);
        bus(off, 4'h0, 32'h0, d, ec);
    endtask

    task automatic wait_irq(input int budget, output int rise);
        rise = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin rise = cyc; break; end
        end
    endtask

    task automatic start_session(input int p, input int n, input int r, input bit au);
        int ec;
        wr32(8'h00, 32'h0, ec);
        wr32(8'h10, 32'h1, ec);
        wr32(8'h04, 32'(p), ec);
        wr32(8'h08, 32'(r), ec);
        wr32(8'h0C, 32'(n), ec);
        s_p = p; s_n = n; s_r = r; s_auto = au;
        wr32(8'h00, {29'b0, 1'b1, au, 1'b1}, ec);
        s_c0 = ec;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        int ec;
        n_cmp++;
        if ({ready, rdata, irq} !== 34'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b/%h/%b, want 0/0/0", ready, rdata, irq);
        end
        for (int i = 0; i < 5; i++) begin
            rd32(8'(i * 4), v, ec);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++; $display("FAIL reset_read off=%0h: got %h, want 0", i * 4, v);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({ready, rdata} !== 33'b0) begin
            n_bad++; $display("FAIL ready_pulse_width: got %b/%h, want 0/0", ready, rdata);
        end
    endtask

    task automatic test_strobes;
        logic [31:0] sh [4];
        logic [31:0] msk [4];
        logic [31:0] v, wd, exp_v;
        logic [3:0] ws;
        logic [7:0] off;
        int ec, idx, hits;
        msk[0] = 32'h7; msk[1] = 32'hFFFF; msk[2] = 32'hFFFF_FFFF; msk[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        bus(8'h0C, 4'b0101, 32'hAABB_CCDD, v, ec);
        sh[3] = 32'h00BB_00DD;
        rd32(8'h0C, v, ec);
        n_cmp++;
        if (v !== 32'h00BB_00DD) begin
            n_bad++; $display("FAIL strobe_fixed: got %h, want 00bb00dd", v);
        end
        for (int it = 0; it < 16; it++) begin
            idx = $urandom_range(0, 4);
            ws = 4'($urandom_range(1, 15));
            wd = $urandom;
            if (idx == 0) wd[0] = 1'b0;
            off = (idx < 4) ? 8'(idx * 4) : 8'(8'h14 + 4 * $urandom_range(0, 58));
            bus(off, ws, wd, v, ec);
            if (idx < 4) sh[idx] = lanes(sh[idx], wd, ws) & msk[idx];
            idx = $urandom_range(0, 4);
            off = (idx < 4) ? 8'(idx * 4) : 8'(8'h14 + 4 * $urandom_range(0, 58));
            off = off | 8'($urandom_range(0, 3));
            rd32(off, v, ec);
            exp_v = (idx < 4) ? sh[idx] : 32'h0;
            n_cmp++;
            if (v !== exp_v) begin
                n_bad++; $display("FAIL strobe_rand off=%h: got %h, want %h", off, v, exp_v);
            end
        end
        @(negedge clk);
        valid = 1'b1; addr = 32'h0400_000C; wstrb = 4'hF; wdata = 32'h1234_5678;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) hits++;
        end
        valid = 1'b0; wstrb = 4'h0;
        n_cmp++;
        if (hits != 0) begin
            n_bad++; $display("FAIL out_of_window_ready: got %0d pulses, want 0", hits);
        end
        rd32(8'h0C, v, ec);
        n_cmp++;
        if (v !== sh[3]) begin
            n_bad++; $display("FAIL out_of_window_side_effect: got %h, want %h", v, sh[3]);
        end
        wr32(8'h00, 32'h0, ec);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        logic exp_r;
        int ec;
        v = $urandom;
        wr32(8'h08, v, ec);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b1; addr = BASE | 32'h8; wstrb = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_r = (i % 2 == 0);
            n_cmp++;
            if ({ready, rdata} !== {exp_r, exp_r ? v : 32'h0}) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %b/%h, want %b/%h", i, ready, rdata,
                         exp_r, exp_r ? v : 32'h0);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_one_shot;
        logic [31:0] v;
        int ec, p, n, rise, highs;
        for (int r = 0; r < 5; r++) begin
            p = (r == 0) ? 3 : $urandom_range(0, 5);
            n = (r == 0) ? 2 : $urandom_range(1, 6);
            start_session(p, n, $urandom_range(1, 9), 1'b0);
            wait_irq(400, rise);
            n_cmp++;
            if (rise - s_c0 != n * (p + 1)) begin
                n_bad++;
                $display("FAIL oneshot_delay p=%0d n=%0d: got %0d, want %0d", p, n, rise - s_c0,
                         n * (p + 1));
            end
            rd32(8'h0C, v, ec);
            n_cmp++;
            if (v !== 32'(count_at(ec))) begin
                n_bad++; $display("FAIL oneshot_count: got %h, want %h", v, count_at(ec));
            end
            rd32(8'h10, v, ec);
            n_cmp++;
            if (v !== 32'h1) begin
                n_bad++; $display("FAIL oneshot_status: got %h, want 1", v);
            end
            wr32(8'h10, 32'h1, ec);
            n_cmp++;
            if (irq !== 1'b0) begin
                n_bad++; $display("FAIL oneshot_w1c: got irq=%b, want 0", irq);
            end
            highs = 0;
            for (int i = 0; i < 3 * (p + 1) + 4; i++) begin
                @(posedge clk); #1;
                if (irq === 1'b1) highs++;
            end
            n_cmp++;
            if (highs != 0) begin
                n_bad++; $display("FAIL oneshot_rearm: got %0d irq cycles, want 0", highs);
            end
        end
    endtask

    task automatic test_auto_reload;
        logic [31:0] v;
        int ec, p, n, r, rise, exp_e;
        for (int rd_i = 0; rd_i < 4; rd_i++) begin
            p = (rd_i == 0) ? 0 : $urandom_range(0, 3);
            n = (rd_i == 0) ? 1 : $urandom_range(1, 5);
            r = (rd_i == 0) ? 4 : $urandom_range(1, 6);
            start_session(p, n, r, 1'b1);
            wait_irq(200, rise);
            n_cmp++;
            if (rise != s_c0 + n * (p + 1)) begin
                n_bad++;
                $display("FAIL auto_first p=%0d n=%0d: got %0d, want %0d", p, n, rise - s_c0,
                         n * (p + 1));
            end
            for (int j = 0; j < 5; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                rd32(8'h0C, v, ec);
                n_cmp++;
                if (v !== 32'(count_at(ec))) begin
                    n_bad++;
                    $display("FAIL auto_count p=%0d n=%0d r=%0d: got %h, want %h", p, n, r, v,
                             count_at(ec));
                end
            end
            for (int j = 0; j < 3; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                wr32(8'h10, 32'h1, ec);
                exp_e = next_expiry(ec);
                if (irq === 1'b1) rise = ec;
                else wait_irq(200, rise);
                n_cmp++;
                if (rise != exp_e) begin
                    n_bad++;
                    $display("FAIL auto_reexpire r=%0d: got %0d, want %0d", r, rise - s_c0,
                             exp_e - s_c0);
                end
            end
        end
        wr32(8'h00, 32'h0, rise);
    endtask

    task automatic test_collisions;
        logic [31:0] v, val;
        int ec, tgt, we;
        start_session(0, 1, 4, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 20 && next_expiry(cyc + 1) != cyc + 1; i++) begin
            @(posedge clk); #1;
        end
        tgt = cyc + 1;
        wr32(8'h10, 32'h1, ec);
        n_cmp++;
        if (ec != tgt || irq !== 1'b1) begin
            n_bad++; $display("FAIL w1c_vs_expire: got edge %0d irq=%b, want %0d 1", ec, irq, tgt);
        end
        rd32(8'h10, v, ec);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++; $display("FAIL w1c_vs_expire_status: got %h, want 1", v);
        end
        start_session(3, 1000, 5, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 20 && ((cyc + 1 - s_c0) % 4 != 0); i++) begin
            @(posedge clk); #1;
        end
        tgt = cyc + 1;
        val = 32'($urandom_range(100, 1000));
        wr32(8'h0C, val, we);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) repeat ($urandom_range(5, 15)) @(posedge clk);
            rd32(8'h0C, v, ec);
            n_cmp++;
            if (we != tgt || v !== val - 32'(ticks_before(ec) - ticks_before(we + 1))) begin
                n_bad++;
                $display("FAIL count_write_vs_tick rd%0d: got %h @%0d, want %h @%0d", k, v, we,
                         val - 32'(ticks_before(ec) - ticks_before(we + 1)), tgt);
            end
        end
        wr32(8'h00, 32'h0, ec);
    endtask

    task automatic test_reset_midop;
        logic [31:0] v;
        int ec, rise;
        start_session(0, 1, 3, 1'b1);
        wait_irq(50, rise);
        @(negedge clk);
        valid = 1'b1; addr = BASE | 32'hC; wstrb = 4'h0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ready, irq} !== 2'b11) begin
            n_bad++; $display("FAIL pre_reset_state: got ready=%b irq=%b, want 1 1", ready, irq);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({ready, rdata, irq} !== 34'b0) begin
            n_bad++; $display("FAIL async_reset: got %b/%h/%b, want 0/0/0", ready, rdata, irq);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_in_reset: got %b, want 0", ready);
        end
        @(negedge clk);
        valid = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd32(8'(i * 4), v, ec);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++; $display("FAIL post_reset_read off=%0h: got %h, want 0", i * 4, v);
            end
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_irq: got %b, want 0", irq);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_strobes();
        test_back_to_back();
        test_one_shot();
        test_auto_reload();
        test_collisions();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
